// File: rtl/and_or_selftest.sv
// Built-in self-test sequencer for a registered 4-input AND-OR unit.
// It sweeps all 16 input vectors {a,b,c,d} through the unit on consecutive
// cycles. It compares the unit's registered result f against (a&b)|(c&d),
// lining each expected value up with the unit's LAT-cycle latency. It counts
// the mismatches and captures the index of the first failing vector.

module and_or_selftest #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [1:0] DRAIN_LAST = 2'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } state_t;

    // One slot of the expected-value delay pipe.
    typedef struct packed {
        logic       valid;
        logic       expect_f;
        logic [3:0] idx;
    } pipe_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] vec;
    logic [1:0] drain_cnt;
    pipe_t      pipe [LAT];
    pipe_t      pipe_out;
    logic       start_accept;
    logic       mismatch;

    // A start request is honoured only when no sweep is running.
    assign start_accept = start && ((state == IDLE) || (state == DONE));

    assign pipe_out = pipe[LAT-1];
    assign mismatch = pipe_out.valid && (f != pipe_out.expect_f);

    // State register.
    // NOTE: state is updated with <= so that every flop in this edge sees the
    // pre-edge values, which is what makes the edge-by-edge timing hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: sweep 16 vectors, then drain LAT cycles, then hold results.
    // NOTE: state_next gets its default before the case, so no path through
    // this block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_accept) state_next = DRIVE;
            DRIVE:   if (vec == 4'd15) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:    if (start_accept) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    // Stimulus counter. It starts at 0 on entry to DRIVE, steps once per DRIVE
    // edge and wraps 15->0 on the edge that leaves DRIVE. Everywhere else it
    // holds 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 vec <= 4'd0;
        else if (state == DRIVE) vec <= vec + 4'd1;
        else                     vec <= 4'd0;
    end

    // Counts the LAT edges spent in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 drain_cnt <= 2'd0;
        else if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
        else                     drain_cnt <= 2'd0;
    end

    // Expected-value pipe. Slot 0 captures the vector currently on {a,b,c,d}.
    // That vector was launched on the previous edge, so together with the LAT
    // slots a vector launched at edge t reaches the compare at edge t+LAT+1.
    // NOTE: the pipe is reset in full, not just its valid bits, so a reset
    // mid-sweep cannot leave a stale compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid:    (state == DRIVE),
                         expect_f: (vec[3] & vec[2]) | (vec[1] & vec[0]),
                         idx:      vec};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Result registers: cleared by an accepted start, updated on each mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_count       <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else if (start_accept) begin
            fail_count       <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else if (mismatch) begin
            fail_count <= fail_count + 5'd1;
            if (!first_fail_valid) begin
                first_fail_vec   <= pipe_out.idx;
                first_fail_valid <= 1'b1;
            end
        end
    end

    assign {a, b, c, d} = vec;
    assign busy         = (state == DRIVE) || (state == DRAIN);
    assign done         = (state == DONE);
    assign pass         = done && (fail_count == 5'd0);

endmodule

// File: tb/tb_and_or_selftest.sv
// Directed testbench for and_or_selftest. Three instances run side by side.
// dut1 (LAT=1) tests a 1-stage unit whose output can be forced stuck at 0
// or stuck at 1. dut3 (LAT=3) tests a correct 3-stage unit. dut3b (LAT=1) is
// wrongly attached to a 3-stage unit.

module tb_and_or_selftest;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;          // dut1 unit: 0 correct, 1 stuck-at-0, 2 stuck-at-1
    int   errors = 0;
    int   checks = 0;

    logic       a1, b1, c1, d1, busy1, done1, pass1, ffvalid1, f1;
    logic [4:0] fail1;
    logic [3:0] ffvec1;
    logic       a3, b3, c3, d3, busy3, done3, pass3, ffvalid3, f3;
    logic [4:0] fail3;
    logic [3:0] ffvec3;
    logic       ax, bx, cx, dx, busyx, donex, passx, ffvalidx, fx;
    logic [4:0] failx;
    logic [3:0] ffvecx;

    logic       u1;
    logic [2:0] u3, ux;

    always #5 clk = ~clk;

    and_or_selftest #(.LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .f(f1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fail1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffvalid1)
    );

    and_or_selftest #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .f(f3),
        .a(a3), .b(b3), .c(c3), .d(d3),
        .busy(busy3), .done(done3), .pass(pass3), .fail_count(fail3),
        .first_fail_vec(ffvec3), .first_fail_valid(ffvalid3)
    );

    and_or_selftest #(.LAT(1)) dut3b (
        .clk(clk), .rst(rst), .start(start), .f(fx),
        .a(ax), .b(bx), .c(cx), .d(dx),
        .busy(busyx), .done(donex), .pass(passx), .fail_count(failx),
        .first_fail_vec(ffvecx), .first_fail_valid(ffvalidx)
    );

    // Units under test: registered (a&b)|(c&d) with 1 or 3 stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u1 <= 1'b0;
            u3 <= 3'd0;
            ux <= 3'd0;
        end else begin
            u1 <= (a1 & b1) | (c1 & d1);
            u3 <= {u3[1:0], (a3 & b3) | (c3 & d3)};
            ux <= {ux[1:0], (ax & bx) | (cx & dx)};
        end
    end

    assign f1 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : u1;
    assign f3 = u3[2];
    assign fx = ux[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // Pulse start for one edge. Then sample at each falling edge: k is the
    // number of rising edges since the start-sampling edge. Returns the first
    // k at which each instance shows done (-1 if never within the bound).
    task automatic sweep(input bit check_vecs, output int t1, output int t3, output int tx);
        t1 = -1; t3 = -1; tx = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (check_vecs && k <= 15) check($sformatf("vec_%0d", k), {a1, b1, c1, d1}, k);
            if (check_vecs && k == 0)  check("busy_at_launch", busy1, 1);
            if (check_vecs && k == 16) check("drain_zero_busy", {busy1, a1, b1, c1, d1}, 5'b10000);
            if (done1 && t1 < 0) t1 = k;
            if (done3 && t3 < 0) t3 = k;
            if (donex && tx < 0) tx = k;
        end
    endtask

    initial begin
        int t1, t3, tx, tdone;

        // Reset state and idling afterwards.
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {a1, b1, c1, d1, busy1, done1, pass1, fail1, ffvec1, ffvalid1}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_reset", {busy1, done1, a1, b1, c1, d1}, 0);

        // Correct units: LAT=1 and LAT=3 pass; the 3-stage unit behind LAT=1 fails.
        mode = 0;
        sweep(1'b1, t1, t3, tx);
        check("good_done_cycle", t1, 17);
        check("good_results", {pass1, fail1, ffvalid1, busy1}, {1'b1, 5'd0, 1'b0, 1'b0});
        check("lat3_done_cycle", t3, 19);
        check("lat3_pass", {pass3, fail3}, {1'b1, 5'd0});
        check("lat_mismatch_pass", passx, 0);
        check("lat_mismatch_count", failx, 6);
        check("lat_mismatch_first", {ffvalidx, ffvecx}, {1'b1, 4'b0011});

        // f stuck at 0.
        do_reset();
        mode = 1;
        sweep(1'b0, t1, t3, tx);
        check("sa0_count", fail1, 7);
        check("sa0_first", {ffvalid1, ffvec1}, {1'b1, 4'b0011});
        check("sa0_pass", {done1, pass1}, 2'b10);

        // f stuck at 1.
        do_reset();
        mode = 2;
        sweep(1'b0, t1, t3, tx);
        check("sa1_count", fail1, 9);
        check("sa1_first", {ffvalid1, ffvec1}, {1'b1, 4'b0000});
        check("sa1_pass", {done1, pass1}, 2'b10);

        // Asynchronous reset while vector 7 is driven, then a clean sweep.
        do_reset();
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_vec7", {a1, b1, c1, d1}, 7);
        check("mid_partial_count", fail1, 1);
        rst = 1'b1;
        #1;
        check("mid_async_clear",
              {a1, b1, c1, d1, busy1, done1, pass1, fail1, ffvec1, ffvalid1}, 0);
        @(negedge clk) rst = 1'b0;
        mode = 0;
        sweep(1'b1, t1, t3, tx);
        check("post_reset_done", t1, 17);
        check("post_reset_clean", {pass1, fail1, ffvalid1}, {1'b1, 5'd0, 1'b0});

        // start held high: no restart while busy; restart from DONE clears results.
        do_reset();
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 15) check($sformatf("held_vec_%0d", k), {busy1, a1, b1, c1, d1}, {1'b1, 4'(k)});
        end
        @(negedge clk);
        check("held_done_k17", {done1, busy1, fail1}, {1'b1, 1'b0, 5'd7});
        @(negedge clk);
        check("restart_clears", {done1, busy1, fail1, ffvalid1, a1, b1, c1, d1},
              {1'b0, 1'b1, 5'd0, 1'b0, 4'd0});
        mode = 0;
        start = 1'b0;
        tdone = -1;
        for (int k = 19; k <= 60; k++) begin
            @(negedge clk);
            if (done1 && tdone < 0) tdone = k;
        end
        check("restart_done_cycle", tdone, 35);
        check("restart_pass", {pass1, fail1, ffvalid1}, {1'b1, 5'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/and_or_selftest.md
AND_OR_SELFTEST -- requirements
Module: and_or_selftest

Interface
REQ-001 Parameter LAT, default 1, meaning: register latency of the attached AND-OR unit in clock edges, legal range 1..3.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request one self-test sweep, sampled on rising edge.
REQ-005 f  input  1  registered result returned by the AND-OR unit under test.
REQ-006 a, b, c, d  output  1 each  stimulus bits driven to the unit under test, registered.
REQ-007 busy  output  1  high while a sweep or drain is in progress.
REQ-008 done  output  1  high while results are held after a completed sweep.
REQ-009 pass  output  1  high when done=1 and fail_count=0.
REQ-010 fail_count  output  5  number of mismatching vectors in the last sweep, 0..16.
REQ-011 first_fail_vec  output  4  index {a,b,c,d} of the first mismatching vector.
REQ-012 first_fail_valid  output  1  high when first_fail_vec holds a captured mismatch.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, DRAIN and DONE.
REQ-014 In IDLE, an edge sampling start=1 SHALL load {a,b,c,d}=0, clear fail_count, first_fail_vec and first_fail_valid, and enter DRIVE.
REQ-015 In DRIVE, each edge SHALL advance {a,b,c,d} by one, 0 through 15, one vector per cycle, no gaps.
REQ-016 The edge after vector 15 is launched SHALL load {a,b,c,d}=0 and enter DRAIN.
REQ-017 Each launch SHALL push expected=(a&b)|(c&d) of the launched vector, its index and a valid bit into a LAT-stage delay pipe; non-launch edges push valid=0.
REQ-018 On every edge where the pipe output is valid, f SHALL be compared with the delayed expected value, so a vector launched at edge t is checked at edge t+LAT+1.
REQ-019 On a mismatch, fail_count SHALL increment by one; if first_fail_valid=0, first_fail_vec SHALL take the delayed index and first_fail_valid SHALL set.
REQ-020 DRAIN SHALL last exactly LAT cycles; the edge performing the vector-15 compare SHALL enter DONE and register that compare's result.
REQ-021 done SHALL rise 16+LAT cycles after the start-sampling edge; busy SHALL be high in DRIVE and DRAIN only.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 In DONE, fail_count, first_fail_vec, first_fail_valid, pass and done SHALL hold until start=1 is sampled, which behaves as REQ-014 (done drops, busy rises).
REQ-024 {a,b,c,d} SHALL be 0 in IDLE, DRAIN and DONE.
REQ-025 fail_count SHALL never exceed 16 and needs no saturation logic.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, {a,b,c,d}=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, first_fail_valid=0, and all pipe valid bits to 0.
REQ-027 Reset asserted mid-sweep SHALL discard all in-flight compares; no partial results survive.
REQ-028 After rst deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-029 Correct LAT=1 unit, start pulse -> vectors 0..15 on consecutive cycles, done after 17 cycles, pass=1, fail_count=0, first_fail_valid=0.
REQ-030 f stuck at 0 -> fail_count=7, first_fail_vec=4'b0011, first_fail_valid=1, pass=0.
REQ-031 f stuck at 1 -> fail_count=9, first_fail_vec=4'b0000, pass=0.
REQ-032 LAT=3 with a correct 3-stage unit -> pass=1, done 19 cycles after start; the same unit with LAT=1 -> pass=0.
REQ-033 rst pulse while vector 7 is driven -> all outputs 0 asynchronously; a later start runs a full sweep from vector 0 with clean counts.
REQ-034 start held high throughout the sweep -> no restart while busy; a new start in DONE clears results and repeats the sweep.
